// File: rtl/mul_arbiter_pkg.sv
// Shared types and widths for the two-requester multiplier arbiter.
package mul_arbiter_pkg;

    localparam int unsigned WORD  = 32;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_A,
        ST_SEND_B,
        ST_WAIT_Z,
        ST_RETURN,
        ST_HALT
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on a tie the requester that did not win last time wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        if (req == 2'b11) gnt_id = ~last_grant;
        else              gnt_id = req[1];
    end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one stb/ack multiplier between two operand requesters, round-robin,
// with a watchdog on the multiplier result and a completed-operation counter.
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WORD-1:0]  req0_a,
    input  logic [WORD-1:0]  req0_b,
    input  logic             req0_stb,
    output logic             req0_ack,
    input  logic [WORD-1:0]  req1_a,
    input  logic [WORD-1:0]  req1_b,
    input  logic             req1_stb,
    output logic             req1_ack,
    output logic [WORD-1:0]  res0_z,
    output logic             res0_stb,
    input  logic             res0_ack,
    output logic [WORD-1:0]  res1_z,
    output logic             res1_stb,
    input  logic             res1_ack,
    output logic [WORD-1:0]  mul_a,
    output logic [WORD-1:0]  mul_b,
    output logic             mul_a_stb,
    output logic             mul_b_stb,
    input  logic             mul_a_ack,
    input  logic             mul_b_ack,
    input  logic [WORD-1:0]  mul_z,
    input  logic             mul_z_stb,
    output logic             mul_z_ack,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] done_count
);

    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             grant_q, grant_d;
    logic [WORD-1:0]  mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [WORD-1:0]  res0_z_q, res0_z_d, res1_z_q, res1_z_d;
    logic             req0_ack_q, req0_ack_d, req1_ack_q, req1_ack_d;
    logic             mul_a_stb_q, mul_a_stb_d, mul_b_stb_q, mul_b_stb_d;
    logic             mul_z_ack_q, mul_z_ack_d;
    logic             res0_stb_q, res0_stb_d, res1_stb_q, res1_stb_d;
    logic             busy_q, busy_d, err_q, err_d;
    logic [15:0]      wdog_q, wdog_d;
    logic [CNT_W-1:0] done_q, done_d;
    logic             gnt_valid, gnt_id;

    rr_arbiter2 u_rr (
        .req        ({req1_stb, req0_stb}),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        res0_z_d     = res0_z_q;
        res1_z_d     = res1_z_q;
        req0_ack_d   = 1'b0;
        req1_ack_d   = 1'b0;
        mul_a_stb_d  = mul_a_stb_q;
        mul_b_stb_d  = mul_b_stb_q;
        mul_z_ack_d  = mul_z_ack_q;
        res0_stb_d   = res0_stb_q;
        res1_stb_d   = res1_stb_q;
        err_d        = err_q;
        wdog_d       = wdog_q;
        done_d       = done_q;
        case (state_q)
            ST_IDLE: if (gnt_valid) begin
                grant_d      = gnt_id;
                last_grant_d = gnt_id;
                mul_a_d      = gnt_id ? req1_a : req0_a;
                mul_b_d      = gnt_id ? req1_b : req0_b;
                req0_ack_d   = ~gnt_id;
                req1_ack_d   = gnt_id;
                mul_a_stb_d  = 1'b1;
                state_d      = ST_SEND_A;
            end
            ST_SEND_A: if (mul_a_ack) begin
                mul_a_stb_d = 1'b0;
                mul_b_stb_d = 1'b1;
                state_d     = ST_SEND_B;
            end
            ST_SEND_B: if (mul_b_ack) begin
                mul_b_stb_d = 1'b0;
                mul_z_ack_d = 1'b1;
                wdog_d      = '0;
                state_d     = ST_WAIT_Z;
            end
            ST_WAIT_Z: begin
                // A result on the final counted cycle takes priority over the timeout.
                if (mul_z_stb) begin
                    mul_z_ack_d = 1'b0;
                    if (grant_q) begin
                        res1_stb_d = 1'b1;
                        res1_z_d   = mul_z;
                    end else begin
                        res0_stb_d = 1'b1;
                        res0_z_d   = mul_z;
                    end
                    state_d = ST_RETURN;
                end else if (wdog_q == WDOG_LAST) begin
                    err_d       = 1'b1;
                    mul_z_ack_d = 1'b0;
                    state_d     = ST_HALT;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
            end
            ST_RETURN: if (grant_q ? res1_ack : res0_ack) begin
                res0_stb_d = 1'b0;
                res1_stb_d = 1'b0;
                done_d     = done_q + 1'b1;
                state_d    = ST_IDLE;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            res0_z_q     <= '0;
            res1_z_q     <= '0;
            req0_ack_q   <= 1'b0;
            req1_ack_q   <= 1'b0;
            mul_a_stb_q  <= 1'b0;
            mul_b_stb_q  <= 1'b0;
            mul_z_ack_q  <= 1'b0;
            res0_stb_q   <= 1'b0;
            res1_stb_q   <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            wdog_q       <= '0;
            done_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            res0_z_q     <= res0_z_d;
            res1_z_q     <= res1_z_d;
            req0_ack_q   <= req0_ack_d;
            req1_ack_q   <= req1_ack_d;
            mul_a_stb_q  <= mul_a_stb_d;
            mul_b_stb_q  <= mul_b_stb_d;
            mul_z_ack_q  <= mul_z_ack_d;
            res0_stb_q   <= res0_stb_d;
            res1_stb_q   <= res1_stb_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            wdog_q       <= wdog_d;
            done_q       <= done_d;
        end
    end

    assign req0_ack   = req0_ack_q;
    assign req1_ack   = req1_ack_q;
    assign res0_z     = res0_z_q;
    assign res0_stb   = res0_stb_q;
    assign res1_z     = res1_z_q;
    assign res1_stb   = res1_stb_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign mul_a_stb  = mul_a_stb_q;
    assign mul_b_stb  = mul_b_stb_q;
    assign mul_z_ack  = mul_z_ack_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign done_count = done_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: requesters, responders and a table-driven
// multiplier stand-in all act on the falling edge.
module tb_mul_arbiter;

    typedef struct { logic [31:0] a; logic [31:0] b; } pair_t;
    typedef struct { int unsigned ch; logic [31:0] z; } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_stb = 1'b0, req1_stb = 1'b0, req0_ack, req1_ack;
    logic [31:0] res0_z, res1_z;
    logic        res0_stb, res1_stb, res0_ack = 1'b0, res1_ack = 1'b0;
    logic [31:0] mul_a, mul_b, mul_z = '0;
    logic        mul_a_stb, mul_b_stb, mul_a_ack = 1'b0, mul_b_ack = 1'b0;
    logic        mul_z_stb = 1'b0, mul_z_ack, busy, err;
    logic [15:0] done_count;

    mul_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req0_a(req0_a), .req0_b(req0_b), .req0_stb(req0_stb), .req0_ack(req0_ack),
        .req1_a(req1_a), .req1_b(req1_b), .req1_stb(req1_stb), .req1_ack(req1_ack),
        .res0_z(res0_z), .res0_stb(res0_stb), .res0_ack(res0_ack),
        .res1_z(res1_z), .res1_stb(res1_stb), .res1_ack(res1_ack),
        .mul_a(mul_a), .mul_b(mul_b), .mul_a_stb(mul_a_stb), .mul_b_stb(mul_b_stb),
        .mul_a_ack(mul_a_ack), .mul_b_ack(mul_b_ack),
        .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
        .busy(busy), .err(err), .done_count(done_count)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0, n_err = 0;

    // Written by the main sequence only.
    pair_t q0[$], q1[$];
    int    a_stall = 0, b_stall = 0, r1_stall = 0, lat = 3, z_kill = 0;
    bit    z_en = 1'b1;

    // Written by the stand-in process only.
    res_t        rlog[$];
    int          q0_rd = 0, q1_rd = 0, zcnt = 0, a_cnt = 0, b_cnt = 0, r1_cnt = 0, z_kill_seen = 0;
    int unsigned cyc = 0, t_req0 = 0, t_res0 = 0, t_b = 0, t_err = 0;
    int unsigned n_a = 0, n_b = 0, n_z = 0, unstable = 0, n_res1_hi = 0;
    bit          xfer0 = 0, xfer1 = 0, z_pend = 0, err_prev = 0;
    bit          a_seen = 0, b_seen = 0, r0_seen = 0, r1_seen = 0;
    logic [31:0] a_ref, b_ref, r0_ref, r1_ref, cap_a = '0, cap_b = '0;

    int rd = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fake_mul(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40000000, 32'h40400000}: return 32'h40C00000;
            {32'h3FC00000, 32'h40000000}: return 32'h40400000;
            {32'h40800000, 32'h3F000000}: return 32'h40000000;
            {32'hC0000000, 32'h40400000}: return 32'hC0C00000;
            {32'h3F800000, 32'h41200000}: return 32'h41200000;
            {32'h40A00000, 32'h40A00000}: return 32'h41C80000;
            default:                      return 32'hDEADBEEF;
        endcase
    endfunction

    function automatic logic [31:0] flags();
        return {23'd0, req0_ack, req1_ack, mul_a_stb, mul_b_stb, mul_z_ack,
                res0_stb, res1_stb, busy, err};
    endfunction

    task automatic wait_ops(input int n, input int budget);
        int k = 0;
        while (rlog.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("op_wait", 32'(rlog.size()), 32'(n));
        repeat (2) @(negedge clk);
    endtask

    task automatic check_res(input string tag, input int unsigned ch, input logic [31:0] z);
        if (rd < rlog.size()) begin
            check({tag, "_ch"}, rlog[rd].ch, ch);
            check({tag, "_z"}, rlog[rd].z, z);
        end else begin
            check({tag, "_missing"}, 32'(rlog.size()), 32'(rd + 1));
        end
        rd++;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : stand_in
        forever begin
            @(negedge clk);
            cyc++;
            if (err && !err_prev) t_err = cyc;
            err_prev = err;
            // requesters: the value seen at this edge is what the DUT samples next
            if (xfer0) begin q0_rd++; xfer0 = 1'b0; end
            if (q0_rd < q0.size()) begin
                if (!req0_stb && !busy) t_req0 = cyc;
                req0_stb = 1'b1; req0_a = q0[q0_rd].a; req0_b = q0[q0_rd].b;
            end else req0_stb = 1'b0;
            xfer0 = req0_stb && req0_ack;
            if (xfer1) begin q1_rd++; xfer1 = 1'b0; end
            if (q1_rd < q1.size()) begin
                req1_stb = 1'b1; req1_a = q1[q1_rd].a; req1_b = q1[q1_rd].b;
            end else req1_stb = 1'b0;
            xfer1 = req1_stb && req1_ack;
            // multiplier result
            if (z_kill != z_kill_seen) begin z_kill_seen = z_kill; mul_z_stb = 1'b0; zcnt = 0; end
            if (z_pend) begin mul_z_stb = 1'b0; z_pend = 1'b0; end
            if (zcnt > 0) begin
                zcnt--;
                if (zcnt == 0) begin mul_z = fake_mul(cap_a, cap_b); mul_z_stb = 1'b1; end
            end
            z_pend = mul_z_stb && mul_z_ack;
            if (z_pend) n_z++;
            // multiplier operand ports
            if (mul_a_stb) begin
                if (!a_seen) begin a_seen = 1'b1; a_ref = mul_a; a_cnt = a_stall; end
                else if (mul_a !== a_ref) unstable++;
                if (a_cnt > 0) begin a_cnt--; mul_a_ack = 1'b0; end
                else begin mul_a_ack = 1'b1; cap_a = mul_a; a_seen = 1'b0; n_a++; end
            end else begin mul_a_ack = 1'b0; a_seen = 1'b0; end
            if (mul_b_stb) begin
                if (!b_seen) begin b_seen = 1'b1; b_ref = mul_b; b_cnt = b_stall; end
                else if (mul_b !== b_ref) unstable++;
                if (b_cnt > 0) begin b_cnt--; mul_b_ack = 1'b0; end
                else begin
                    mul_b_ack = 1'b1; cap_b = mul_b; b_seen = 1'b0; n_b++; t_b = cyc;
                    if (z_en) zcnt = lat + 1;
                end
            end else begin mul_b_ack = 1'b0; b_seen = 1'b0; end
            // result consumers
            if (res0_stb) begin
                if (!r0_seen) begin r0_seen = 1'b1; r0_ref = res0_z; end
                else if (res0_z !== r0_ref) unstable++;
                res0_ack = 1'b1; rlog.push_back('{ch: 0, z: res0_z}); t_res0 = cyc; r0_seen = 1'b0;
            end else begin res0_ack = 1'b0; r0_seen = 1'b0; end
            if (res1_stb) begin
                n_res1_hi++;
                if (!r1_seen) begin r1_seen = 1'b1; r1_ref = res1_z; r1_cnt = r1_stall; end
                else if (res1_z !== r1_ref) unstable++;
                if (r1_cnt > 0) begin r1_cnt--; res1_ack = 1'b0; end
                else begin res1_ack = 1'b1; rlog.push_back('{ch: 1, z: res1_z}); r1_seen = 1'b0; end
            end else begin res1_ack = 1'b0; r1_seen = 1'b0; end
        end
    end

    initial begin : guard
        #200000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin : main
        int unsigned base_a, base_b, base_z, k;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_flags", flags(), 32'h0);
        check("rst_done", 32'(done_count), 32'h0);
        check("rst_mul_a", mul_a, 32'h0);
        check("rst_mul_b", mul_b, 32'h0);
        check("rst_res0_z", res0_z, 32'h0);
        check("rst_res1_z", res1_z, 32'h0);

        // single request, 3-cycle multiplier
        q0.push_back('{a: 32'h40000000, b: 32'h40400000});
        wait_ops(1, 40);
        check_res("single", 0, 32'h40C00000);
        check("single_lat", t_res0 - t_req0, 32'd7);
        check("single_res1_hi", n_res1_hi, 32'd0);
        check("single_done", 32'(done_count), 32'd1);
        check("single_busy", 32'(busy), 32'd0);

        // tie from reset, both requesters held over six operations
        pulse_rst();
        q0.push_back('{a: 32'h40000000, b: 32'h40400000});
        q1.push_back('{a: 32'h3FC00000, b: 32'h40000000});
        q0.push_back('{a: 32'h40800000, b: 32'h3F000000});
        q1.push_back('{a: 32'hC0000000, b: 32'h40400000});
        q0.push_back('{a: 32'h3F800000, b: 32'h41200000});
        q1.push_back('{a: 32'h40A00000, b: 32'h40A00000});
        wait_ops(rd + 6, 150);
        check_res("tie0", 0, 32'h40C00000);
        check_res("tie1", 1, 32'h40400000);
        check_res("tie2", 0, 32'h40000000);
        check_res("tie3", 1, 32'hC0C00000);
        check_res("tie4", 0, 32'h41200000);
        check_res("tie5", 1, 32'h41C80000);
        check("tie_done", 32'(done_count), 32'd6);

        // back-pressure on both operand ports and on the channel-1 result
        a_stall = 5; b_stall = 5; r1_stall = 5;
        base_a = n_a; base_b = n_b; base_z = unstable;
        q1.push_back('{a: 32'hC0000000, b: 32'h40400000});
        wait_ops(rd + 1, 60);
        check_res("bp", 1, 32'hC0C00000);
        check("bp_unstable", unstable - base_z, 32'd0);
        check("bp_a_xfers", n_a - base_a, 32'd1);
        check("bp_b_xfers", n_b - base_b, 32'd1);
        check("bp_done", 32'(done_count), 32'd7);
        a_stall = 0; b_stall = 0; r1_stall = 0;

        // watchdog: multiplier never answers
        z_en = 1'b0;
        q0.push_back('{a: 32'h40000000, b: 32'h40400000});
        k = 0;
        while (!err && k < 60) begin @(negedge clk); k++; end
        @(negedge clk);
        // err is first visible on the falling edge after the TIMEOUT-th WAIT_Z edge
        check("wd_delay", t_err - t_b, 32'd9);
        check("wd_halt", flags(), 32'h3);
        repeat (5) @(negedge clk);
        check("wd_sticky", flags(), 32'h3);
        pulse_rst();
        check("wd_cleared", flags(), 32'h0);
        z_en = 1'b1;

        // reset while waiting on the multiplier, late result must not be taken
        lat = 6;
        q0.push_back('{a: 32'h3FC00000, b: 32'h40000000});
        k = 0;
        while (!mul_z_ack && k < 40) begin @(negedge clk); k++; end
        check("rm_reach_wait", 32'(mul_z_ack), 32'd1);
        pulse_rst();
        check("rm_flags", flags(), 32'h0);
        check("rm_mul_a", mul_a, 32'h0);
        check("rm_mul_b", mul_b, 32'h0);
        base_z = n_z;
        repeat (10) @(negedge clk);
        check("rm_late_z_not_acked", n_z - base_z, 32'd0);
        check("rm_no_result", 32'(rlog.size()), 32'(rd));
        z_kill++;
        lat = 3;
        @(negedge clk);
        q0.push_back('{a: 32'h40800000, b: 32'h3F000000});
        wait_ops(rd + 1, 40);
        check_res("rm_next", 0, 32'h40000000);
        check("rm_done", 32'(done_count), 32'd1);

        // counter wrap
        force dut.done_q = 16'hFFFF;
        @(negedge clk);
        release dut.done_q;
        @(negedge clk);
        check("wrap_pre", 32'(done_count), 32'h0000FFFF);
        q1.push_back('{a: 32'h40A00000, b: 32'h40A00000});
        wait_ops(rd + 1, 40);
        check_res("wrap_op", 1, 32'h41C80000);
        check("wrap_done", 32'(done_count), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
